// File: rtl/register_gp_pkg.sv
// Shared types and helpers for the general-purpose register.
// Operation encoding plus the request decoder that fixes op priority.
package reg_gp_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_SHL,
    OP_SHR,
    OP_ERR
  } op_t;

  // Width of a bus-select field; a single bus still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Priority: load > shl > shr > inc/dec. Conflicting pairs decode to OP_ERR.
  function automatic op_t decode_op(input logic load, input logic inc,
                                    input logic dec, input logic shl,
                                    input logic shr);
    op_t op;
    if (load)             op = OP_LOAD;
    else if (shl && shr)  op = OP_ERR;
    else if (shl)         op = OP_SHL;
    else if (shr)         op = OP_SHR;
    else if (inc && dec)  op = OP_ERR;
    else if (inc)         op = OP_INC;
    else if (dec)         op = OP_DEC;
    else                  op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/register_gp_tristate_driver.sv
// Single tri-state bus driver: drives d onto q when en, else releases q.
// Shared by every register that drives the 6502 internal buses.
module tristate_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  inout  wire  [WIDTH-1:0] q
);

  assign q = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/register_gp.sv
// General-purpose 6502 datapath register: input bus select, inc/dec with
// wrap pulse, N/Z status, sticky illegal-request flag, NUM_OUT tri-state
// output buses. Optional shift unit enabled by macro REGISTER_GP_SHIFT_EN
// (adds shl/shr inputs and a carry output).
module register_gp
  import reg_gp_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NUM_IN    = 2,
  parameter int               NUM_OUT   = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_IN*WIDTH-1:0]          data_in,
  input  logic [sel_width(NUM_IN)-1:0]     in_sel,
  input  logic                             load,
  input  logic                             inc,
  input  logic                             dec,
`ifdef REGISTER_GP_SHIFT_EN
  input  logic                             shl,
  input  logic                             shr,
  output logic                             carry,
`endif
  input  logic [NUM_OUT-1:0]               bus_enable,
  inout  wire  [NUM_OUT*WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]                 value,
  output logic                             flag_n,
  output logic                             flag_z,
  output logic                             wrap,
  output logic                             op_err
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             shl_i, shr_i;
  logic             carry_q, carry_d;
  op_t              op;
  int               sel_idx;

`ifdef REGISTER_GP_SHIFT_EN
  assign shl_i = shl;
  assign shr_i = shr;
  assign carry = carry_q;
`else
  assign shl_i = 1'b0;
  assign shr_i = 1'b0;
`endif

  assign op      = decode_op(load, inc, dec, shl_i, shr_i);
  assign sel_idx = int'(32'(in_sel));

  // Next-state: one case on the decoded op; out-of-range load select is an error.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    carry_d = carry_q;
    case (op)
      OP_LOAD: begin
        if (sel_idx >= NUM_IN) err_d = 1'b1;
        else value_d = data_in[sel_idx*WIDTH +: WIDTH];
      end
      OP_INC: begin
        value_d = value_q + 1'b1;
        wrap_d  = (value_q == {WIDTH{1'b1}});
      end
      OP_DEC: begin
        value_d = value_q - 1'b1;
        wrap_d  = (value_q == '0);
      end
      OP_SHL: begin
        value_d = {value_q[WIDTH-2:0], 1'b0};
        carry_d = value_q[WIDTH-1];
      end
      OP_SHR: begin
        value_d = {1'b0, value_q[WIDTH-1:1]};
        carry_d = value_q[0];
      end
      OP_ERR:  err_d = 1'b1;
      default: ;
    endcase
  end

  // All register state; async reset restores RESET_VAL and clears flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      carry_q <= carry_d;
    end
  end

`ifndef REGISTER_GP_SHIFT_EN
  // Without the shift unit carry never changes and has no consumer.
  logic carry_unused;
  assign carry_unused = carry_q;
`endif

  assign value  = value_q;
  assign flag_n = value_q[WIDTH-1];
  assign flag_z = (value_q == '0);
  assign wrap   = wrap_q;
  assign op_err = err_q;

  // One driver per output bus; enables are purely combinational.
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    tristate_driver #(.WIDTH(WIDTH)) u_drv (
      .en (bus_enable[j]),
      .d  (value_q),
      .q  (data_out[j*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_register_gp.sv
// Directed bench for register_gp (WIDTH=8, two input and two output buses,
// RESET_VAL=FD). Output buses are pulled low so a released bus reads 00.
module tb_register_gp;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic [2*W-1:0] data_in;
  logic [0:0]    in_sel;
  logic          load, inc, dec;
  logic [1:0]    bus_enable;
  tri0  [2*W-1:0] data_out;
  logic [W-1:0]  value;
  logic          flag_n, flag_z, wrap, op_err;
`ifdef REGISTER_GP_SHIFT_EN
  logic          shl, shr, carry;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  register_gp #(
    .WIDTH(W), .NUM_IN(2), .NUM_OUT(2), .RESET_VAL(8'hFD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_sel(in_sel),
    .load(load), .inc(inc), .dec(dec),
`ifdef REGISTER_GP_SHIFT_EN
    .shl(shl), .shr(shr), .carry(carry),
`endif
    .bus_enable(bus_enable), .data_out(data_out), .value(value),
    .flag_n(flag_n), .flag_z(flag_z), .wrap(wrap), .op_err(op_err)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 0; inc = 0; dec = 0;
`ifdef REGISTER_GP_SHIFT_EN
    shl = 0; shr = 0;
`endif
  endtask

  task automatic do_load(input logic [0:0] sel, input logic [W-1:0] v);
    idle();
    in_sel = sel;
    if (sel == 1'b0) data_in[W-1:0] = v;
    else             data_in[2*W-1:W] = v;
    load = 1;
    step();
    load = 0;
  endtask

  task automatic do_inc();
    idle(); inc = 1; step(); inc = 0;
  endtask

  task automatic do_dec();
    idle(); dec = 1; step(); dec = 0;
  endtask

  initial begin
    rst_n = 1; data_in = '0; in_sel = '0; bus_enable = 2'b10;
    idle();
    #1 rst_n = 0;
    #2;
    // Reset state, before any clock edge.
    check("rst_value",  value, 8'hFD);
    check("rst_flag_n", flag_n, 1);
    check("rst_flag_z", flag_z, 0);
    check("rst_bus1",   data_out[15:8], 8'hFD);
    check("rst_bus0",   data_out[7:0], 8'h00);
    check("rst_wrap",   wrap, 0);
    check("rst_op_err", op_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Load 00 then inc x3, dec x3.
    do_load(1'b0, 8'h00);
    check("ld0_value", value, 8'h00);
    check("ld0_flag_z", flag_z, 1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      do_inc();
      check("inc_seq", value, exp_q.pop_front());
      check("inc_seq_wrap", wrap, 0);
    end
    check("seq_bus1", data_out[15:8], 8'h03);
    for (int i = 0; i < 3; i++) begin
      do_dec();
      check("dec_seq", value, exp_q.pop_front());
    end
    check("seq_end_flag_z", flag_z, 1);

    // Combinational bus enables.
    bus_enable = 2'b11; #1;
    check("both_bus0", data_out[7:0], 8'h00);
    do_load(1'b1, 8'hA5);
    check("both_bus0_a5", data_out[7:0], 8'hA5);
    check("both_bus1_a5", data_out[15:8], 8'hA5);
    bus_enable = 2'b01; #1;
    check("en01_bus0", data_out[7:0], 8'hA5);
    check("en01_bus1", data_out[15:8], 8'h00);

    // Wrap on inc from FF and dec from 00.
    do_load(1'b0, 8'hFF);
    check("ff_flag_n", flag_n, 1);
    do_inc();
    check("incwrap_value", value, 8'h00);
    check("incwrap_flag_z", flag_z, 1);
    check("incwrap_wrap", wrap, 1);
    idle(); step();
    check("incwrap_pulse_end", wrap, 0);
    do_dec();
    check("decwrap_value", value, 8'hFF);
    check("decwrap_flag_n", flag_n, 1);
    check("decwrap_wrap", wrap, 1);
    do_dec();
    check("dec_nowrap", wrap, 0);
    check("dec_nowrap_value", value, 8'hFE);

    // Load beats inc; then inc+dec conflict is sticky.
    idle();
    data_in[15:8] = 8'h42; in_sel = 1'b1; load = 1; inc = 1;
    step();
    check("ldinc_value", value, 8'h42);
    check("ldinc_wrap", wrap, 0);
    check("ldinc_op_err", op_err, 0);
    idle(); inc = 1; dec = 1;
    step();
    check("conflict_value", value, 8'h42);
    check("conflict_op_err", op_err, 1);
    idle(); step(); step();
    check("op_err_sticky", op_err, 1);
    do_inc();
    check("op_err_sticky_inc", op_err, 1);
    check("after_conflict_inc", value, 8'h43);

    // Async reset mid-cycle during an inc burst.
    do_load(1'b0, 8'h10);
    idle(); inc = 1;
    step();
    check("burst_1", value, 8'h11);
    #2 rst_n = 0;
    #1;
    check("async_rst_value", value, 8'hFD);
    check("async_rst_op_err", op_err, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("resume_1", value, 8'hFE);
    step();
    check("resume_2", value, 8'hFF);
    step();
    check("resume_3", value, 8'h00);
    check("resume_wrap", wrap, 1);
    idle();

`ifdef REGISTER_GP_SHIFT_EN
    // Shift unit.
    do_load(1'b0, 8'h81);
    check("sh_carry_init", carry, 0);
    idle(); shl = 1; step();
    check("shl_value", value, 8'h02);
    check("shl_carry", carry, 1);
    idle(); shr = 1; step();
    check("shr_value", value, 8'h01);
    check("shr_carry", carry, 0);
    idle(); shl = 1; shr = 1; step();
    check("shlshr_value", value, 8'h01);
    check("shlshr_op_err", op_err, 1);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
